imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Registered immediate generator for the decode stage. Accepts a 32-bit RV instruction.
//  Decodes the opcode to an immediate format and builds the sign-extended XLEN immediate.
//  Result is delivered over a valid/ready handshake with a skid buffer, giving full
//  throughput under backpressure. Sits between fetch/decode and the ALU operand mux.
// PARAMETERS
//  XLEN        32   immediate output width; legal values 32 or 64
//  FMT_W       3    width of format code (fixed; exposed for package consistency)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active-high
//  flush        in   1      synchronous pipeline flush
//  in_valid     in   1      instruction valid
//  in_ready     out  1      block can accept instruction this cycle
//  in_instr     in   32     instruction word
//  out_valid    out  1      immediate valid
//  out_ready    in   1      consumer accepts this cycle
//  out_imm      out  XLEN   sign/zero-extended immediate
//  out_fmt      out  3      format code: I=000 S=001 B=010 U=011 J=100 Z=101 NONE=111
//  out_illegal  out  1      opcode not recognised
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-high.
//  - Reset values: out_valid=0, out_imm=0, out_fmt=111, out_illegal=0, skid empty.
//  - in_ready = !skid_valid && !flush && !rst. Handshakes complete when valid&&ready are both high at a rising edge.
//  - Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N.
//  - Skid buffer:
//      - If the output is stalled (out_valid && !out_ready) and an input is accepted,
//        the new result goes to the skid register.
//      - in_ready drops next cycle.
//      - When the output handshake completes, the skid entry moves to the output.
//      - Order is preserved; no entry is dropped or duplicated.
//  - Outputs hold stable while out_valid && !out_ready.
//  - Decode on opcode[6:0]:
//      - 0010011/0000011/1100111 -> I: sext(i[31:20])
//      - 0100011 -> S: sext({i[31:25],i[11:7]})
//      - 1100011 -> B: sext({i[31],i[7],i[30:25],i[11:8],1'b0})
//      - 0110111/0010111 -> U: {sext(i[31:12]),12'b0}
//      - 1101111 -> J: sext({i[31],i[19:12],i[20],i[30:21],1'b0})
//      - 1110011 -> I (see CONFIGURATION for Z)
//      - 0110011/0001111 -> NONE, imm=0, illegal=0
//      - any other opcode -> NONE, imm=0, illegal=1
//  - Sign extension replicates i[31] up to XLEN-1; XLEN=64 U-type is also sign-extended.
//  - flush:
//      - On the next edge, clears out_valid and the skid entry.
//      - Any concurrent input is not accepted (in_ready=0).
//      - flush has priority over every handshake.
//  - Simultaneous out handshake + in accept with skid empty: output reloads directly, skid stays empty.
//  - Reset mid-transfer: all buffered entries are discarded immediately (async); in_ready=0 while rst is high.
// CONFIGURATION
//  - Macro IMM_GEN_CSR_EN.
//  - Defined: opcode 1110011 with funct3[2]=1 -> fmt Z, imm = zero-extended i[19:15].
//    funct3[2]=0 -> fmt I.
//  - Undefined: all 1110011 -> fmt I; code 101 is never produced.
// STRUCTURE
//  - Package imm_gen_pkg:
//      - format-code localparams (FMT_I..FMT_NONE)
//      - opcode constants
//      - typedef imm_fmt_t (3-bit)
//  - Sub-module imm_decode_comb: pure combinational instr -> {imm, fmt, illegal}.
//    Instantiated once, feeding the output and skid registers.
//  - Top: output register, skid register, handshake control.
// TESTING
//  - Reset/idle: rst pulse mid-stream -> out_valid=0, out_fmt=111, out_imm=0 immediately; in_ready=1 after release.
//  - Formats, XLEN=32:
//      - addi x1,x0,-1 (0xFFF00093) -> fmt 000, imm 0xFFFFFFFF
//      - beq offset -4 (0xFE000EE3) -> fmt 010, imm 0xFFFFFFFC
//      - lui 0x12345 (0x123450B7) -> fmt 011, imm 0x12345000
//  - Backpressure:
//      - Stream 3 instrs with out_ready=0 from cycle 2 -> in_ready falls after 2nd accept.
//      - Raise out_ready -> all 3 emerge in order, no loss.
//  - Flush with skid full -> next cycle out_valid=0, in_ready=1, nothing further emitted.
//  - Illegal/NONE: 0x0000007F -> fmt 111, illegal=1; add (0x00000033) -> fmt 111, illegal=0, imm 0.
//  - XLEN=64 with IMM_GEN_CSR_EN:
//      - csrrwi (0x3400D073) -> fmt 101, imm 0x1
//      - jal -2 -> imm 0xFFFFFFFFFFFFFFFE

Source files
------------

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: format codes, opcode constants and the format type shared by the immediate generator.
package imm_gen_pkg;
  localparam int IMM_FMT_W = 3;
  typedef logic [IMM_FMT_W-1:0] imm_fmt_t;
  localparam imm_fmt_t FMT_I    = 3'b000;
  localparam imm_fmt_t FMT_S    = 3'b001;
  localparam imm_fmt_t FMT_B    = 3'b010;
  localparam imm_fmt_t FMT_U    = 3'b011;
  localparam imm_fmt_t FMT_J    = 3'b100;
  localparam imm_fmt_t FMT_Z    = 3'b101;
  localparam imm_fmt_t FMT_NONE = 3'b111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode_comb: combinational opcode -> immediate format, sign-extended immediate, illegal flag.
// IMM_GEN_CSR_EN: SYSTEM opcodes with funct3[2]=1 yield fmt Z with zero-extended uimm.
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_t        o_fmt,
  output logic            o_illegal
);
  always_comb begin
    o_imm = '0;
    o_fmt = FMT_NONE;
    o_illegal = 1'b0;
    case (i_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        o_fmt = FMT_I;
        o_imm = XLEN'($signed(i_instr[31:20]));
      end
      OP_STORE: begin
        o_fmt = FMT_S;
        o_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
      end
      OP_BRANCH: begin
        o_fmt = FMT_B;
        o_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        o_fmt = FMT_U;
        o_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
      end
      OP_JAL: begin
        o_fmt = FMT_J;
        o_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));
      end
      OP_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
        if (i_instr[14]) begin
          o_fmt = FMT_Z;
          o_imm = XLEN'(i_instr[19:15]);
        end else
`endif
        begin
          o_fmt = FMT_I;
          o_imm = XLEN'($signed(i_instr[31:20]));
        end
      end
      OP_REG, OP_FENCE: begin
      end
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a one-entry skid buffer on a valid/ready output.
// IMM_GEN_CSR_EN (in imm_decode_comb) enables the Z format for CSR immediate instructions.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int FMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [FMT_W-1:0] out_fmt,
  output logic             out_illegal
);
  logic [XLEN-1:0] w_imm;
  imm_fmt_t        w_fmt;
  logic            w_ill;
  logic            w_accept;
  logic            w_load;
  logic            r_out_v;
  logic [XLEN-1:0] r_out_imm;
  imm_fmt_t        r_out_fmt;
  logic            r_out_ill;
  logic            r_skid_v;
  logic [XLEN-1:0] r_skid_imm;
  imm_fmt_t        r_skid_fmt;
  logic            r_skid_ill;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .i_instr   (in_instr),
    .o_imm     (w_imm),
    .o_fmt     (w_fmt),
    .o_illegal (w_ill)
  );

  assign in_ready    = !r_skid_v && !flush && !rst;
  assign w_accept    = in_valid && in_ready;
  assign w_load      = !r_out_v || out_ready;
  assign out_valid   = r_out_v;
  assign out_imm     = r_out_imm;
  assign out_fmt     = r_out_fmt;
  assign out_illegal = r_out_ill;

  // The skid only fills while the output is stalled and drains before any new accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_v    <= 1'b0;
      r_out_imm  <= '0;
      r_out_fmt  <= FMT_NONE;
      r_out_ill  <= 1'b0;
      r_skid_v   <= 1'b0;
      r_skid_imm <= '0;
      r_skid_fmt <= FMT_NONE;
      r_skid_ill <= 1'b0;
    end else if (flush) begin
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_load) begin
      r_out_v <= r_skid_v || w_accept;
      if (r_skid_v) begin
        r_out_imm <= r_skid_imm;
        r_out_fmt <= r_skid_fmt;
        r_out_ill <= r_skid_ill;
        r_skid_v  <= 1'b0;
      end else if (w_accept) begin
        r_out_imm <= w_imm;
        r_out_fmt <= w_fmt;
        r_out_ill <= w_ill;
      end
    end else if (w_accept) begin
      r_skid_v   <= 1'b1;
      r_skid_imm <= w_imm;
      r_skid_fmt <= w_fmt;
      r_skid_ill <= w_ill;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe (XLEN=32 stream plus an XLEN=64 instance).
module tb_imm_gen_pipe;
  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, out_imm;
  logic [2:0]  out_fmt;
  logic        v64, rdy64, ov64, ill64;
  logic [31:0] i64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        stalled = 1'b0;
  logic [31:0] s_imm;
  logic [2:0]  s_fmt;
  logic        s_ill;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(v64), .in_ready(rdy64), .in_instr(i64),
    .out_valid(ov64), .out_ready(1'b1),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
    int k = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) chk("accept_timeout", {63'b0, in_ready}, 64'd1);
    else q.push_back('{imm, fmt, ill});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send64(input logic [31:0] ins, input logic [63:0] imm, input logic [2:0] fmt);
    @(negedge clk);
    v64 = 1'b1;
    i64 = ins;
    @(posedge clk);
    #1 v64 = 1'b0;
    @(negedge clk);
    #1;
    chk("x64_valid", {63'b0, ov64}, 64'd1);
    chk("x64_imm", imm64, imm);
    chk("x64_fmt", {61'b0, fmt64}, {61'b0, fmt});
  endtask

  // Output side: pop on every completed handshake, and hold-stable check while stalled
  always @(negedge clk) begin
    #1;
    if (!rst && out_valid) begin
      if (stalled) begin
        chk("hold_imm", {32'b0, out_imm}, {32'b0, s_imm});
        chk("hold_fmt", {61'b0, out_fmt}, {61'b0, s_fmt});
      end
      if (out_ready) begin
        if (q.size() == 0) chk("spurious_out", {63'b0, out_valid}, 64'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("imm", {32'b0, out_imm}, {32'b0, e.imm});
          chk("fmt", {61'b0, out_fmt}, {61'b0, e.fmt});
          chk("illegal", {63'b0, out_illegal}, {63'b0, e.ill});
        end
      end
    end
    stalled = out_valid && !out_ready;
    s_imm = out_imm;
    s_fmt = out_fmt;
    s_ill = out_illegal;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    v64 = 1'b0; i64 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_fmt", {61'b0, out_fmt}, 64'd7);
    chk("rst_imm", {32'b0, out_imm}, 64'd0);
    chk("rst_ready", {63'b0, in_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_rst", {63'b0, in_ready}, 64'd1);
    // back-to-back stream with the consumer always ready
    send(32'hFFF00093, 32'hFFFFFFFF, 3'b000, 1'b0);
    send(32'hFE000EE3, 32'hFFFFFFFC, 3'b010, 1'b0);
    send(32'h123450B7, 32'h12345000, 3'b011, 1'b0);
    send(32'hFE112C23, 32'hFFFFFFF8, 3'b001, 1'b0);
    send(32'hFFFFF06F, 32'hFFFFFFFE, 3'b100, 1'b0);
    send(32'h0000007F, 32'h00000000, 3'b111, 1'b1);
    send(32'h00000033, 32'h00000000, 3'b111, 1'b0);
    send(32'h00500093, 32'h00000005, 3'b000, 1'b0);
`ifdef IMM_GEN_CSR_EN
    send(32'h3400D073, 32'h00000001, 3'b101, 1'b0);
`else
    send(32'h3400D073, 32'h00000340, 3'b000, 1'b0);
`endif
    repeat (3) @(negedge clk);
    // backpressure: second accept lands in the skid and closes in_ready
    out_ready = 1'b0;
    send(32'h00100093, 32'h00000001, 3'b000, 1'b0);
    send(32'h00200093, 32'h00000002, 3'b000, 1'b0);
    @(negedge clk);
    #1 chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    send(32'h00300093, 32'h00000003, 3'b000, 1'b0);
    repeat (4) @(negedge clk);
    chk("bp_drained", 64'(q.size()), 64'd0);
    // flush with skid full, concurrent input must be refused
    out_ready = 1'b0;
    send(32'h00400093, 32'h00000004, 3'b000, 1'b0);
    send(32'h00600093, 32'h00000006, 3'b000, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00700093;
    #1 chk("flush_in_ready", {63'b0, in_ready}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    q.delete();
    #1;
    chk("flush_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    // asynchronous reset with both entries occupied
    out_ready = 1'b0;
    send(32'h0000007F, 32'h00000000, 3'b111, 1'b1);
    send(32'h123450B7, 32'h12345000, 3'b011, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_fmt", {61'b0, out_fmt}, 64'd7);
    chk("arst_imm", {32'b0, out_imm}, 64'd0);
    chk("arst_ill", {63'b0, out_illegal}, 64'd0);
    chk("arst_ready", {63'b0, in_ready}, 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arst_release_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    send(32'hFFF00093, 32'hFFFFFFFF, 3'b000, 1'b0);
    repeat (3) @(negedge clk);
    // XLEN=64 instance
    send64(32'hFFFFF06F, 64'hFFFFFFFFFFFFFFFE, 3'b100);
    send64(32'h800000B7, 64'hFFFFFFFF80000000, 3'b011);
`ifdef IMM_GEN_CSR_EN
    send64(32'h3400D073, 64'h0000000000000001, 3'b101);
`else
    send64(32'h3400D073, 64'h0000000000000340, 3'b000);
`endif
    repeat (2) @(negedge clk);
    chk("final_drain", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
